// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus monitor: captures each strobed digit once stable, decodes to BCD,
// and hands complete frames to a valid/ready consumer.
module seg7_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cap_i,
    input  logic       clr_i,
    input  logic [3:0] nib_i,
    input  logic       err_i,
    output logic [3:0] nib_o,
    output logic       err_o,
    output logic       mask_o
);
    logic [3:0] nib_q;
    logic       err_q;
    logic       mask_q;

    // Capture and frame-clear never coincide: a slot is always HELD the edge after capturing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_q  <= '0;
            err_q  <= 1'b0;
            mask_q <= 1'b0;
        end else if (cap_i) begin
            nib_q  <= nib_i;
            err_q  <= err_i;
            mask_q <= 1'b1;
        end else if (clr_i) begin
            mask_q <= 1'b0;
        end
    end

    assign nib_o  = nib_q;
    assign err_o  = err_q;
    assign mask_o = mask_q;
endmodule

module seg7_scan_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_i,
    input  logic [NDIG-1:0]     an_i,
    output logic [4*NDIG-1:0]   digits_o,
    output logic [NDIG-1:0]     dig_err_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                overrun_o
);
    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [6:0]        seg_q, segp_q;
    logic [NDIG-1:0]   an_q, anp_q;

    logic                   samp_oh, samp_same, cap_en, frame_done;
    logic [3:0]             dec_nib;
    logic                   dec_err;
    logic [NDIG-1:0][3:0]   stg_nib;
    logic [NDIG-1:0]        stg_err, mask;

    logic [4*NDIG-1:0]  digits_q, digits_d;
    logic [NDIG-1:0]    dig_err_q, dig_err_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    assign samp_oh   = (an_q != '0) && ((an_q & (an_q - 1'b1)) == '0);
    assign samp_same = (seg_q == segp_q) && (an_q == anp_q);
    // cnt_q counts repeats after the first sample, so the STABLE_CYC-th identical sample
    // arrives while cnt_q == STABLE_CYC-2.
    assign cap_en    = (state_q == S_SETTLE) && samp_oh && samp_same &&
                       (cnt_q == CNT_W'(STABLE_CYC - 2));
    assign frame_done = &mask;

    always_comb begin
        dec_err = 1'b0;
        case (seg_q)
            7'b1111110: dec_nib = 4'd0;
            7'b0110000: dec_nib = 4'd1;
            7'b1101101: dec_nib = 4'd2;
            7'b1111001: dec_nib = 4'd3;
            7'b0110011: dec_nib = 4'd4;
            7'b1011011: dec_nib = 4'd5;
            7'b1011111: dec_nib = 4'd6;
            7'b1110000: dec_nib = 4'd7;
            7'b1111111: dec_nib = 4'd8;
            7'b1111011: dec_nib = 4'd9;
            default: begin
                dec_nib = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Input registers, previous-sample history and dwell FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= '0;
            an_q    <= '0;
            segp_q  <= '0;
            anp_q   <= '0;
            state_q <= S_WAIT;
            cnt_q   <= '0;
        end else begin
            seg_q  <= seg_i;
            an_q   <= an_i;
            segp_q <= seg_q;
            anp_q  <= an_q;
            if (!samp_oh) begin
                state_q <= S_WAIT;
                cnt_q   <= '0;
            end else if (state_q == S_WAIT || !samp_same) begin
                state_q <= S_SETTLE;
                cnt_q   <= '0;
            end else if (state_q == S_SETTLE) begin
                if (cap_en) begin
                    state_q <= S_HELD;
                    cnt_q   <= '0;
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NDIG; i++) begin : g_slot
        seg7_slot u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .cap_i  (cap_en && an_q[i]),
            .clr_i  (frame_done),
            .nib_i  (dec_nib),
            .err_i  (dec_err),
            .nib_o  (stg_nib[i]),
            .err_o  (stg_err[i]),
            .mask_o (mask[i])
        );
    end

    always_comb begin
        digits_d  = digits_q;
        dig_err_d = dig_err_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (frame_done) begin
            if (!valid_q || out_ready_i) begin
                digits_d  = stg_nib;
                dig_err_d = stg_err;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= '0;
            dig_err_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            dig_err_q <= dig_err_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign digits_o    = digits_q;
    assign dig_err_o   = dig_err_q;
    assign out_valid_o = valid_q;
    assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: frame assembly, dwell filtering, handshake, overrun, reset.
module tb_seg7_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  seg = '0;
    logic [3:0]  an = '0;
    logic [15:0] digits;
    logic [3:0]  dig_err;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_i       (seg),
        .an_i        (an),
        .digits_o    (digits),
        .dig_err_o   (dig_err),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [3:0] a, input logic [6:0] s, input int n);
        @(negedge clk);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
    endtask

    // v == 10 drives a blank (all segments off) pattern.
    task automatic dig(input int pos, input int v);
        logic [6:0] s;
        s = (v < 10) ? seg_tab[v] : 7'b0000000;
        drv(4'(1 << pos), s, 8);
    endtask

    task automatic frame(input int d0, input int d1, input int d2, input int d3);
        dig(0, d0); dig(1, d1); dig(2, d2); dig(3, d3);
        drv(4'b0000, 7'b0, 2);
        #1;
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk(tag, 32'(out_valid), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_err", 32'(dig_err), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // T1: basic frame and completion latency
        dig(0, 1); dig(1, 2); dig(2, 3);
        drv(4'b1000, seg_tab[4], 5);
        #1 chk("t1_before", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 chk("t1_latency", 32'(out_valid), 32'd1);
        chk("t1_digits", 32'(digits), 32'h4321);
        chk("t1_err", 32'(dig_err), 32'h0);
        drv(4'b1000, seg_tab[4], 2);
        accept("t1_accept");

        // T2: short dwell must not capture
        drv(4'b0010, seg_tab[9], 3);
        drv(4'b0000, 7'b0, 4);
        dig(0, 5); dig(2, 6); dig(3, 7);
        drv(4'b0000, 7'b0, 3);
        #1 chk("t2_no_frame", 32'(out_valid), 32'd0);
        dig(1, 9);
        drv(4'b0000, 7'b0, 2);
        #1 chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_digits", 32'(digits), 32'h7695);
        accept("t2_accept");

        // T3: blank digit decodes as error
        frame(1, 2, 10, 3);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_digits", 32'(digits), 32'h3F21);
        chk("t3_err", 32'(dig_err), 32'b0100);
        accept("t3_accept");

        // T4: overrun when consumer stalls
        frame(1, 2, 3, 4);
        chk("t4_first", 32'(digits), 32'h4321);
        frame(5, 6, 7, 8);
        chk("t4_held_digits", 32'(digits), 32'h4321);
        chk("t4_held_valid", 32'(out_valid), 32'd1);
        chk("t4_overrun", 32'(overrun), 32'd1);
        accept("t4_accept");
        chk("t4_sticky", 32'(overrun), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        #1 chk("rst2_overrun", 32'(overrun), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // T5: completion on the accept edge
        frame(1, 2, 3, 4);
        chk("t5_first", 32'(out_valid), 32'd1);
        dig(0, 9); dig(1, 8); dig(2, 7);
        drv(4'b1000, seg_tab[5], 5);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_digits", 32'(digits), 32'h5789);
        chk("t5_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 chk("t5_drop", 32'(out_valid), 32'd0);
        @(negedge clk) out_ready = 1'b0;

        // T6: multi-hot strobe ignored, then async reset mid-frame
        frame(1, 2, 3, 4);
        dig(2, 5); dig(3, 6);
        drv(4'b0011, seg_tab[8], 10);
        drv(4'b0000, 7'b0, 3);
        #1 chk("t6_no_cap", 32'(overrun), 32'd0);
        chk("t6_digits", 32'(digits), 32'h4321);
        dig(0, 7);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_digits", 32'(digits), 32'h0);
        chk("t6_rst_err", 32'(dig_err), 32'h0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        dig(1, 1);
        drv(4'b0000, 7'b0, 3);
        #1 chk("t6_discard", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
